// File: rtl/player_move_ctrl.sv
// Player movement requester: turns direction keys into single-cycle move requests,
// holds the request stable until acknowledged or timed out, and owns the committed
// player state (position, floor, keys, health, facing).
module player_move_ctrl #(
    parameter int unsigned MAP_WIDTH     = 11,
    parameter int unsigned MAP_HEIGHT    = 11,
    parameter int unsigned INIT_X        = 5,
    parameter int unsigned INIT_Y        = 10,
    parameter int unsigned INIT_FLOOR    = 0,
    parameter int unsigned INIT_KEYS     = 0,
    parameter int unsigned INIT_HEALTH   = 1000,
    parameter int unsigned REPEAT_CYCLES = 5000000,
    parameter int unsigned ACK_TIMEOUT   = 15
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        key_up_i,
    input  logic        key_down_i,
    input  logic        key_left_i,
    input  logic        key_right_i,
    input  logic        accept_move_i,
    input  logic [3:0]  goto_x_i,
    input  logic [3:0]  goto_y_i,
    input  logic [15:0] floor_in_i,
    input  logic [31:0] key_num_in_i,
    input  logic [15:0] health_in_i,
    output logic        player_ask_move_o,
    output logic [3:0]  player_ask_x_o,
    output logic [3:0]  player_ask_y_o,
    output logic [3:0]  player_x_o,
    output logic [3:0]  player_y_o,
    output logic [15:0] floor_o,
    output logic [31:0] key_num_o,
    output logic [15:0] health_o,
    output logic [1:0]  facing_o,
    output logic        busy_o,
    output logic        move_timeout_o,
    output logic        dead_o
);

    localparam logic [3:0]  XMax       = 4'(MAP_WIDTH - 1);
    localparam logic [3:0]  YMax       = 4'(MAP_HEIGHT - 1);
    localparam logic [3:0]  InitX      = 4'(INIT_X);
    localparam logic [3:0]  InitY      = 4'(INIT_Y);
    localparam logic [15:0] InitFloor  = 16'(INIT_FLOOR);
    localparam logic [31:0] InitKeys   = 32'(INIT_KEYS);
    localparam logic [15:0] InitHealth = 16'(INIT_HEALTH);
    localparam logic [31:0] RepLast    = 32'(REPEAT_CYCLES - 1);
    localparam logic [15:0] AckLast    = 16'(ACK_TIMEOUT - 1);

    localparam logic [1:0] DirUp    = 2'd0;
    localparam logic [1:0] DirDown  = 2'd1;
    localparam logic [1:0] DirLeft  = 2'd2;
    localparam logic [1:0] DirRight = 2'd3;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StAsk  = 2'd1,
        StWait = 2'd2
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  keys_prev_q;
    logic [31:0] rep_cnt_q, rep_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [3:0]  ask_x_q, ask_x_d;
    logic [3:0]  ask_y_q, ask_y_d;
    logic [3:0]  pos_x_q, pos_x_d;
    logic [3:0]  pos_y_q, pos_y_d;
    logic [15:0] floor_q, floor_d;
    logic [31:0] keys_q, keys_d;
    logic [15:0] health_q, health_d;
    logic [1:0]  facing_q, facing_d;
    logic        timeout_q, timeout_d;

    logic [3:0] keys;
    logic [3:0] rise;
    logic       held_alone;
    logic       held_face;
    logic       sel_valid;
    logic [1:0] sel_dir;
    logic       blocked;
    logic [3:0] tgt_x;
    logic [3:0] tgt_y;

    // Bit order matches the facing encoding: 0 up, 1 down, 2 left, 3 right.
    assign keys       = {key_right_i, key_left_i, key_down_i, key_up_i};
    assign rise       = keys & ~keys_prev_q;
    assign held_alone = (keys != 4'b0) && ((keys & (keys - 4'd1)) == 4'b0);
    // Auto-repeat only tracks a single key that is also the last selected direction.
    assign held_face  = held_alone && keys[facing_q];

    // Pick a direction: fresh edges by priority, otherwise an expired repeat interval.
    always_comb begin
        sel_valid = 1'b0;
        sel_dir   = facing_q;
        if (rise[0]) begin
            sel_valid = 1'b1;
            sel_dir   = DirUp;
        end else if (rise[1]) begin
            sel_valid = 1'b1;
            sel_dir   = DirDown;
        end else if (rise[2]) begin
            sel_valid = 1'b1;
            sel_dir   = DirLeft;
        end else if (rise[3]) begin
            sel_valid = 1'b1;
            sel_dir   = DirRight;
        end else if (held_face && (rep_cnt_q == RepLast)) begin
            sel_valid = 1'b1;
            sel_dir   = facing_q;
        end
    end

    // Target tile; edge checks happen before the +/-1 so coordinates never wrap.
    always_comb begin
        tgt_x   = pos_x_q;
        tgt_y   = pos_y_q;
        blocked = 1'b0;
        unique case (sel_dir)
            DirUp: begin
                blocked = (pos_y_q == 4'd0);
                tgt_y   = pos_y_q - 4'd1;
            end
            DirDown: begin
                blocked = (pos_y_q == YMax);
                tgt_y   = pos_y_q + 4'd1;
            end
            DirLeft: begin
                blocked = (pos_x_q == 4'd0);
                tgt_x   = pos_x_q - 4'd1;
            end
            DirRight: begin
                blocked = (pos_x_q == XMax);
                tgt_x   = pos_x_q + 4'd1;
            end
        endcase
        if (dead_o) begin
            blocked = 1'b1;
        end
    end

    // Next-state: request handshake, repeat/timeout counters and state commit.
    always_comb begin
        state_d   = state_q;
        rep_cnt_d = rep_cnt_q;
        to_cnt_d  = to_cnt_q;
        ask_x_d   = ask_x_q;
        ask_y_d   = ask_y_q;
        pos_x_d   = pos_x_q;
        pos_y_d   = pos_y_q;
        floor_d   = floor_q;
        keys_d    = keys_q;
        health_d  = health_q;
        facing_d  = facing_q;
        timeout_d = 1'b0;

        unique case (state_q)
            StIdle: begin
                to_cnt_d = 16'd0;
                if (sel_valid) begin
                    facing_d  = sel_dir;
                    rep_cnt_d = 32'd0;
                    if (!blocked) begin
                        state_d = StAsk;
                        ask_x_d = tgt_x;
                        ask_y_d = tgt_y;
                    end
                end else if (held_face) begin
                    rep_cnt_d = rep_cnt_q + 32'd1;
                end else begin
                    rep_cnt_d = 32'd0;
                end
            end
            StAsk: begin
                state_d   = StWait;
                to_cnt_d  = 16'd0;
                rep_cnt_d = 32'd0;
            end
            StWait: begin
                rep_cnt_d = 32'd0;
                // Accept wins over a simultaneous timeout.
                if (accept_move_i) begin
                    state_d  = StIdle;
                    pos_x_d  = goto_x_i;
                    pos_y_d  = goto_y_i;
                    floor_d  = floor_in_i;
                    keys_d   = key_num_in_i;
                    health_d = health_in_i;
                    to_cnt_d = 16'd0;
                end else if (to_cnt_q == AckLast) begin
                    state_d   = StIdle;
                    timeout_d = 1'b1;
                    to_cnt_d  = 16'd0;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State registers with asynchronous reset to the initial player state.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            keys_prev_q <= 4'b0;
            rep_cnt_q   <= 32'd0;
            to_cnt_q    <= 16'd0;
            ask_x_q     <= InitX;
            ask_y_q     <= InitY;
            pos_x_q     <= InitX;
            pos_y_q     <= InitY;
            floor_q     <= InitFloor;
            keys_q      <= InitKeys;
            health_q    <= InitHealth;
            facing_q    <= DirUp;
            timeout_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            keys_prev_q <= keys;
            rep_cnt_q   <= rep_cnt_d;
            to_cnt_q    <= to_cnt_d;
            ask_x_q     <= ask_x_d;
            ask_y_q     <= ask_y_d;
            pos_x_q     <= pos_x_d;
            pos_y_q     <= pos_y_d;
            floor_q     <= floor_d;
            keys_q      <= keys_d;
            health_q    <= health_d;
            facing_q    <= facing_d;
            timeout_q   <= timeout_d;
        end
    end

    assign player_ask_move_o = (state_q == StAsk);
    assign player_ask_x_o    = ask_x_q;
    assign player_ask_y_o    = ask_y_q;
    assign player_x_o        = pos_x_q;
    assign player_y_o        = pos_y_q;
    assign floor_o           = floor_q;
    assign key_num_o         = keys_q;
    assign health_o          = health_q;
    assign facing_o          = facing_q;
    assign busy_o            = (state_q != StIdle);
    assign move_timeout_o    = timeout_q;
    assign dead_o            = (health_q == 16'd0);

endmodule

// File: doc/player_move_ctrl.md
# player_move_ctrl

Requester side of the tile-interaction handshake. Turns debounced direction keys into single-cycle move requests toward the map-interaction block, holds the request coordinates stable until acknowledged, then commits the returned player position, floor, key count and health into its own state registers. Sits between keyboard/button conditioning and the interaction/rendering logic; its registered state is the authoritative player state fed back to the interaction block.

## Interface
- MAP_WIDTH, 11, tiles per row (≤16)
- MAP_HEIGHT, 11, tiles per column (≤16)
- INIT_X / INIT_Y, 5 / 10, player position after reset
- INIT_FLOOR, 0, floor after reset
- INIT_KEYS, 0, key count after reset
- INIT_HEALTH, 1000, health after reset
- REPEAT_CYCLES, 5000000, cycles a key must stay held before an auto-repeat request (and between repeats)
- ACK_TIMEOUT, 15, max cycles in WAIT before abandoning a request
- clk  in  1  system clock
- rstn  in  1  asynchronous active-low reset
- key_up / key_down / key_left / key_right  in  1 each  debounced, clk-synchronous, active-high levels
- accept_move  in  1  acknowledge pulse from interaction block
- goto_x / goto_y  in  4 each  position to commit on acknowledge
- floor_in  in  16  floor to commit
- key_num_in  in  32  key count to commit
- health_in  in  16  health to commit
- player_ask_move  out  1  one-cycle request strobe
- player_ask_x / player_ask_y  out  4 each  requested target tile
- player_x / player_y  out  4 each  committed position
- floor  out  16, key_num  out  32, health  out  16  committed state
- facing  out  2  last pressed direction: 0 up, 1 down, 2 left, 3 right
- busy  out  1  high in ASK or WAIT
- move_timeout  out  1  one-cycle pulse when a request is abandoned
- dead  out  1  high while health == 0

## Operation
- States: IDLE, ASK, WAIT. Reset -> IDLE.
- Direction select: rising edge of any key (previous-cycle register), priority up > down > left > right; held key also selects when repeat counter reaches REPEAT_CYCLES-1.
- facing updates on every selected direction, including blocked ones.
- Target: up y-1, down y+1, left x-1, right x+1. Blocked (no request, stay IDLE) if y==0 up, y==MAP_HEIGHT-1 down, x==0 left, x==MAP_WIDTH-1 right, or dead.
- IDLE -> ASK on unblocked selection; player_ask_x/y registered with target the same edge.
- ASK: player_ask_move=1 for exactly this cycle -> WAIT.
- WAIT: player_ask_x/y, player_x/y, floor, key_num, health held constant (interaction block uses them combinationally). On accept_move: register goto_x/y, floor_in, key_num_in, health_in into outputs; -> IDLE; clear repeat counter. If timeout counter reaches ACK_TIMEOUT without accept: no update, move_timeout pulse, -> IDLE.
- Repeat counter: increments in IDLE while the selected key stays held alone at top priority; clears on release, on direction change, and on commit.
- Key edges during ASK/WAIT are discarded (no queueing). accept_move outside WAIT ignored.
- dead is combinational from registered health; no new requests while dead.

## Timing
- Reset values: state IDLE, player_ask_move 0, player_ask_x/y = INIT_X/INIT_Y, player_x/y = INIT_X/INIT_Y, floor INIT_FLOOR, key_num INIT_KEYS, health INIT_HEALTH, facing 0, busy 0, move_timeout 0, repeat/timeout counters 0.
- Key rises at edge N -> player_ask_move high cycle N+1 only. With interaction latency (accept at N+4), committed outputs visible N+5, IDLE at N+5; earliest next request N+6.
- Accept and timeout in same cycle: accept wins.
- Reset mid-WAIT: immediate return to reset values; late accept_move after reset ignored (state IDLE).
- All arithmetic 4-bit on coordinates; bounds checks precede ±1 so no wrap occurs.

## Test plan
- Reset, pulse key_right at (5,10) -> ask strobe 1 cycle with ask=(6,10); accept with goto=(6,10), health_in=900 -> player_x=6, health=900 next cycle, busy low.
- Player at (0,3), press key_left -> no ask, facing=2, busy stays 0.
- Press up, never accept -> busy high 16 cycles, move_timeout pulse, outputs unchanged, state IDLE.
- key_up and key_right rise same cycle at (5,5) -> ask=(5,4), facing=0.
- Hold key_down with REPEAT_CYCLES=8, accept each request at 3 cycles -> second ask 8 IDLE cycles after first commit; release -> no further asks.
- Commit health_in=0 -> dead=1; subsequent key presses produce no ask; assert rstn low mid-WAIT -> all outputs back to INIT values.
